// File: rtl/nios_gpio_pkg.sv
// Shared register map and edge-mode constants for the Nios bidirectional GPIO.
package nios_gpio_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_IRQ_MASK = 3'd2;
  localparam logic [2:0] REG_EDGE_CAP = 3'd3;
  localparam logic [2:0] REG_OUTSET   = 3'd4;
  localparam logic [2:0] REG_OUTCLR   = 3'd5;
  localparam logic [2:0] REG_OD       = 3'd6;
  localparam logic [2:0] REG_RSVD     = 3'd7;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Wide enough to hold SYNC_STAGES+1 for the largest supported depth (4).
  localparam int PRIME_W = 3;

endpackage

// File: rtl/nios_gpio_sync.sv
// Multi-flop input synchroniser for the GPIO pins, asynchronously reset to 0.
module nios_gpio_sync #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] chain_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) chain_q[s] <= '0;
    end else begin
      chain_q[0] <= pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) chain_q[s] <= chain_q[s-1];
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/nios_gpio_bidir_ctrl.sv
// Avalon-MM bidirectional GPIO with atomic set/clear writes and per-pin open-drain drive.
// Edge capture and the maskable interrupt are built only when NIOS_GPIO_EDGE_IRQ_EN is defined.
module nios_gpio_bidir_ctrl
  import nios_gpio_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] wd;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  nios_gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (bidir_port),
    .sync_o  (pin_sync)
  );

  // An open-drain pin only ever pulls low; a high level is left to the board pull-up.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = (dir_q[i] && !(od_q[i] && data_out_q[i])) ? data_out_q[i] : 1'bz;
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    od_d       = od_q;
    if (wr_en) begin
      case (address)
        REG_DATA:   data_out_d = wd;
        REG_DIR:    dir_d      = wd;
        REG_OUTSET: data_out_d = data_out_q | wd;
        REG_OUTCLR: data_out_d = data_out_q & ~wd;
        REG_OD:     od_d       = wd;
        default:    ;
      endcase
    end
  end

`ifdef NIOS_GPIO_EDGE_IRQ_EN
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   cap_q, cap_d;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   edge_hit;
  logic [PRIME_W-1:0] prime_q;
  logic               primed;

  function automatic logic [WIDTH-1:0] edge_detect(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prev);
    case (EDGE_TYPE)
      EDGE_FALL: edge_detect = ~cur & prev;
      EDGE_ANY:  edge_detect = cur ^ prev;
      default:   edge_detect = cur & ~prev;
    endcase
  endfunction

  // Edges are ignored until the synchroniser has been refilled from the live pins.
  assign primed   = (prime_q == PRIME_DONE);
  assign edge_hit = primed ? edge_detect(pin_sync, prev_q) : '0;

  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en && address == REG_IRQ_MASK) mask_d = wd;
    if (wr_en && address == REG_EDGE_CAP) cap_d = cap_q & ~wd;
    cap_d = cap_d | edge_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      cap_q   <= '0;
      prev_q  <= '0;
      prime_q <= '0;
    end else begin
      mask_q <= mask_d;
      cap_q  <= cap_d;
      prev_q <= pin_sync;
      if (!primed) prime_q <= prime_q + PRIME_W'(1);
    end
  end

  assign irq = |(cap_q & mask_q);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata_d = '0;
    case (address)
      REG_DATA:     readdata_d[WIDTH-1:0] = pin_sync;
      REG_DIR:      readdata_d[WIDTH-1:0] = dir_q;
`ifdef NIOS_GPIO_EDGE_IRQ_EN
      REG_IRQ_MASK: readdata_d[WIDTH-1:0] = mask_q;
      REG_EDGE_CAP: readdata_d[WIDTH-1:0] = cap_q;
`endif
      REG_OD:       readdata_d[WIDTH-1:0] = od_q;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
      od_q       <= '0;
      readdata_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      od_q       <= od_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_nios_gpio_bidir_ctrl.sv
// Scoreboard bench for nios_gpio_bidir_ctrl: directed Avalon accesses and pin stimulus.
`timescale 1ns/1ps
module tb_nios_gpio_bidir_ctrl;
  import nios_gpio_pkg::*;

  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  wire  [WIDTH-1:0] bidir_port;
  logic [WIDTH-1:0] tb_oe;
  logic [WIDTH-1:0] tb_val;

  typedef struct {
    int          kind;   // 0 pins, 1 irq, 2 readdata
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t rd_q[$];
  exp_t obs_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rd_vld;

  always #5 clk = ~clk;

  // Board side: optional external drive per pin, weak pull-up otherwise.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ext
    assign bidir_port[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    pullup pu (bidir_port[i]);
  end

  nios_gpio_bidir_ctrl #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (EDGE_RISE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .bidir_port (bidir_port),
    .irq        (irq)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Read data is valid one cycle after a read strobe.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_vld <= 1'b0;
    else          rd_vld <= chipselect & write_n;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", readdata);
      end else begin
        e = rd_q.pop_front();
        cmp(e.nm, readdata, e.exp);
      end
    end
  end

  always @(negedge clk) begin
    exp_t o;
    #2;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      case (o.kind)
        0:       cmp(o.nm, {24'b0, bidir_port}, o.exp);
        1:       cmp(o.nm, {31'b0, irq}, o.exp);
        default: cmp(o.nm, readdata, o.exp);
      endcase
    end
  end

  task automatic cyc();
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    rd_q.push_back('{2, e, nm});
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic obs(input int kind, input logic [31:0] e, input string nm);
    obs_q.push_back('{kind, e, nm});
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    tb_oe = '1; tb_val = '0;
    repeat (3) @(negedge clk);
    obs(2, 32'h0, "reset_readdata");
    obs(1, 32'h0, "reset_irq");
    cyc(); reset_n = 1'b1;
    repeat (2) cyc();

    // Pins pulled low, nothing driven by the block.
    rd(REG_DIR, 32'h0, "dir_reset");
    rd(REG_DATA, 32'h0, "data_pins_low");
    cyc(); tb_oe = '0; obs(0, 32'hFF, "pins_z_pullup");
    cyc(); tb_oe = '1; obs(0, 32'h00, "pins_z_pulldown");
    cyc(); tb_oe = '0;

    // Push-pull output with set/clear.
    wr(REG_DIR, 32'hFF);
    wr(REG_DATA, 32'hA5);    obs(0, 32'hA5, "pins_data_write");
    wr(REG_OUTSET, 32'h02);  obs(0, 32'hA7, "pins_outset");
    wr(REG_OUTCLR, 32'h80);  obs(0, 32'h27, "pins_outclr");
    repeat (2) cyc();
    rd(REG_DATA, 32'h27, "data_readback");
    rd(REG_DIR, 32'hFF, "dir_readback");
    rd(REG_OUTSET, 32'h0, "outset_reads_zero");
    rd(REG_RSVD, 32'h0, "reserved_reads_zero");

    // Open-drain pin 0.
    wr(REG_OD, 32'h01);
    wr(REG_DIR, 32'h01);
    wr(REG_DATA, 32'h01);    obs(0, 32'hFF, "od_high_pullup");
    cyc(); tb_oe = 8'h01; tb_val = 8'h00; obs(0, 32'hFE, "od_high_not_driven");
    cyc(); tb_oe = '0;
    wr(REG_DATA, 32'h00);    obs(0, 32'hFE, "od_low_driven");
    rd(REG_OD, 32'h01, "od_readback");

    wr(REG_OD, 32'h0);
    wr(REG_DIR, 32'h0);
    tb_oe = '1; tb_val = '0;
    repeat (4) cyc();

`ifdef NIOS_GPIO_EDGE_IRQ_EN
    wr(REG_EDGE_CAP, 32'hFF);
    rd(REG_EDGE_CAP, 32'h0, "cap_cleared");
    wr(REG_IRQ_MASK, 32'h01); obs(1, 32'h0, "irq_idle");
    cyc(); tb_val = 8'h01;   obs(1, 32'h0, "irq_edge_t0");
    repeat (2) cyc();        obs(1, 32'h0, "irq_edge_t2");
    cyc();                   obs(1, 32'h1, "irq_edge_t3");
    rd(REG_EDGE_CAP, 32'h01, "cap_rise");
    wr(REG_EDGE_CAP, 32'h01); obs(1, 32'h0, "irq_after_w1c");

    cyc(); tb_val = 8'h03;
    repeat (4) cyc();        obs(1, 32'h0, "irq_masked_pin1");
    rd(REG_EDGE_CAP, 32'h02, "cap_masked_pin1");
    wr(REG_IRQ_MASK, 32'h02); obs(1, 32'h1, "irq_unmasked");
    rd(REG_IRQ_MASK, 32'h02, "mask_readback");
    wr(REG_IRQ_MASK, 32'h00); obs(1, 32'h0, "irq_mask_off");

    cyc(); tb_val = 8'h02;
    repeat (4) cyc();
    rd(REG_EDGE_CAP, 32'h02, "cap_ignores_fall");
    cyc(); tb_val = 8'h03;
    cyc();
    wr(REG_EDGE_CAP, 32'h01);
    rd(REG_EDGE_CAP, 32'h03, "cap_set_beats_w1c");
`else
    wr(REG_IRQ_MASK, 32'hFF);
    rd(REG_IRQ_MASK, 32'h0, "mask_absent");
    cyc(); tb_val = 8'hFF;
    repeat (5) cyc();
    rd(REG_EDGE_CAP, 32'h0, "cap_absent");
    obs(1, 32'h0, "irq_absent");
    rd(REG_DATA, 32'hFF, "data_pins_high");
`endif

    // Reset mid-operation with pins driven low, then release with pins held high.
    cyc(); tb_oe = '0;
    wr(REG_DIR, 32'hFF);
    wr(REG_DATA, 32'h00);    obs(0, 32'h00, "pins_driven_low");
    rd(REG_DIR, 32'hFF, "dir_before_reset");
    cyc(); reset_n = 1'b0;
    obs(0, 32'hFF, "reset_pins_release");
    obs(2, 32'h0, "reset_clears_readdata");
    obs(1, 32'h0, "reset_clears_irq");
    cyc(); tb_oe = '1; tb_val = '1;
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (6) cyc();
    rd(REG_EDGE_CAP, 32'h0, "cap_no_false_edge");
    rd(REG_DATA, 32'hFF, "data_high_after_reset");
`ifdef NIOS_GPIO_EDGE_IRQ_EN
    wr(REG_IRQ_MASK, 32'hFF); obs(1, 32'h0, "irq_no_false_edge");
`endif

    repeat (4) cyc();
    if (rd_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_checks: got %0d expected 0", rd_q.size() + obs_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
